// File: rtl/simple_pkg.sv
// Shared constants and types for the SIMPLE core: opcode fields, phase bit
// indices and the register-index / word types used by the register file.
package simple_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b11;
  localparam logic [4:0] OP_LI  = 5'b10000;

  localparam int PH_RD = 1;
  localparam int PH_WB = 3;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;

  // Operand source fields are fixed by the instruction encoding.
  function automatic reg_idx_t rd_a_idx(input word_t instr);
    return instr[13:11];
  endfunction

  function automatic reg_idx_t rd_b_idx(input word_t instr);
    return instr[10:8];
  endfunction

endpackage

// File: rtl/rf_dest_dec.sv
// Destination-register decode: loads name their target in [13:11], every
// other instruction class (ALU/shift, LI) names it in [10:8].
module rf_dest_dec
  import simple_pkg::*;
(
  input  word_t    instr,
  output reg_idx_t wa_next
);

  always_comb begin
    wa_next = (instr[15:14] == OP_LD) ? instr[13:11] : instr[10:8];
  end

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[7:0];

endmodule

// File: rtl/reg_file.sv
// Eight-entry general-purpose register file: phase-1 operand/destination
// capture, writeback on rf_enable, and a combinational debug read port.
module reg_file
  import simple_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              phase,
  input  logic [15:0]             instr,
  input  logic                    rf_enable,
  input  logic [W-1:0]            result,
  output logic [W-1:0]            ar,
  output logic [W-1:0]            br,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [W-1:0]            dbg_data
);

  logic [W-1:0] regs [NREG];
  reg_idx_t     wa;
  reg_idx_t     wa_next;
  reg_idx_t     ra_idx;
  reg_idx_t     rb_idx;
  logic         fwd_a;
  logic         fwd_b;

  rf_dest_dec u_dest_dec (
    .instr   (instr),
    .wa_next (wa_next)
  );

  assign ra_idx = rd_a_idx(instr);
  assign rb_idx = rd_b_idx(instr);

  // A write landing in the same cycle as a capture goes to the old wa, so the
  // operand must take the incoming result rather than the stale array entry.
  assign fwd_a = rf_enable && (wa == ra_idx);
  assign fwd_b = rf_enable && (wa == rb_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      ar <= '0;
      br <= '0;
      wa <= '0;
    end else begin
      if (rf_enable) begin
        regs[wa] <= result;
      end
      if (phase[PH_RD]) begin
        ar <= fwd_a ? result : regs[ra_idx];
        br <= fwd_b ? result : regs[rb_idx];
        wa <= wa_next;
      end
    end
  end

  // Debug view shows only committed contents; no forwarding here.
  assign dbg_data = regs[dbg_sel];

  logic unused_phase_bits;
  assign unused_phase_bits = ^{phase[4:2], phase[0]};

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a rule-level model of the register file is
// compared on every falling edge, and literal expectations pin each scenario.
module tb_reg_file;

  localparam logic [4:0] P0 = 5'b00001;
  localparam logic [4:0] P1 = 5'b00010;
  localparam logic [4:0] P2 = 5'b00100;
  localparam logic [4:0] P3 = 5'b01000;
  localparam logic [4:0] P4 = 5'b10000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  phase = '0;
  logic [15:0] instr = '0;
  logic        rf_enable = 1'b0;
  logic [15:0] result = '0;
  logic [15:0] ar;
  logic [15:0] br;
  logic [2:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  always #10 clk = ~clk;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .instr     (instr),
    .rf_enable (rf_enable),
    .result    (result),
    .ar        (ar),
    .br        (br),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  // ---------------- model ----------------
  logic [15:0] m_r [8];
  logic [15:0] m_ar;
  logic [15:0] m_br;
  int          m_wa;
  int          total = 0;
  int          bad = 0;
  logic        cmp_on = 1'b0;
  logic [2:0]  dbg_rot = '0;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_ar = 16'h0000;
    m_br = 16'h0000;
    m_wa = 0;
  endtask

  // Rules: a phase-1 cycle reads R[a], R[b] (seeing a same-cycle write to
  // the current destination) and picks the next destination; a strobe writes
  // the destination chosen by the previous phase-1 cycle.
  task automatic model_clock(input logic [4:0] ph, input logic [15:0] ins,
                             input logic en, input logic [15:0] res);
    int old_wa;
    int a;
    int b;
    old_wa = m_wa;
    a = int'(ins[13:11]);
    b = int'(ins[10:8]);
    if (ph[1]) begin
      m_ar = (en && old_wa == a) ? res : m_r[a];
      m_br = (en && old_wa == b) ? res : m_r[b];
      m_wa = (ins[15:14] == 2'b00) ? a : b;
    end
    if (en) m_r[old_wa] = res;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      check("model_ar", ar, m_ar);
      check("model_br", br, m_br);
      check("model_dbg", dbg_data, m_r[dbg_sel]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [4:0] ph, input logic [15:0] ins,
                      input logic en, input logic [15:0] res);
    phase = ph;
    instr = ins;
    rf_enable = en;
    result = res;
    dbg_sel = dbg_rot;
    dbg_rot = dbg_rot + 3'd1;
    @(posedge clk);
    model_clock(ph, ins, en, res);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic en,
                           input logic [15:0] res);
    step(P1, ins, 1'b0, res);
    step(P2, ins, 1'b0, res);
    step(P3, ins, en, res);
    step(P4, ins, 1'b0, res);
    step(P0, ins, 1'b0, res);
  endtask

  task automatic check_regs(input string name, input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check(name, dbg_data, exp_q.pop_front());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_on = 1'b1;

    check("reset_ar", ar, 16'h0000);
    check("reset_br", br, 16'h0000);
    check_regs("reset_regs", '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

    // ALU writeback to R2
    run_instr(16'hCA00, 1'b1, 16'h1234);
    check_regs("alu_wb", '{16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

    // LD destination comes from [13:11]
    run_instr(16'h2000, 1'b1, 16'hBEEF);
    check_regs("ld_wb", '{16'h0, 16'h0, 16'h1234, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h0});

    // Operand read, held while R5 is rewritten
    run_instr(16'hC500, 1'b1, 16'h0055);
    run_instr(16'hC600, 1'b1, 16'h0066);
    step(P1, 16'h2E00, 1'b0, 16'h0000);
    check("op_ar_p2", ar, 16'h0055);
    check("op_br_p2", br, 16'h0066);
    step(P2, 16'h2E00, 1'b0, 16'h0000);
    step(P3, 16'h2E00, 1'b1, 16'h5A5A);
    dbg_sel = 3'd5;
    #1 check("op_r5_rewritten", dbg_data, 16'h5A5A);
    check("op_ar_hold_p4", ar, 16'h0055);
    step(P4, 16'h2E00, 1'b0, 16'h0000);
    check("op_ar_hold", ar, 16'h0055);
    check("op_br_hold", br, 16'h0066);
    step(P0, 16'h2E00, 1'b0, 16'h0000);

    // Forwarding corner: capture and write in the same cycle
    step(P1, 16'hC300, 1'b0, 16'h0000);
    step(P2, 16'hC300, 1'b0, 16'h0000);
    step(P1, 16'hDB00, 1'b1, 16'hA5A5);
    check("fwd_ar", ar, 16'hA5A5);
    check("fwd_br", br, 16'hA5A5);
    dbg_sel = 3'd3;
    #1 check("fwd_r3", dbg_data, 16'hA5A5);
    step(P1, 16'hDF00, 1'b1, 16'h1111);
    check("fwd2_ar", ar, 16'h1111);
    check("fwd2_br", br, 16'h0000);
    step(P2, 16'hDF00, 1'b0, 16'h0000);
    step(P3, 16'hDF00, 1'b1, 16'h7777);
    step(P4, 16'hDF00, 1'b0, 16'h0000);
    step(P0, 16'hDF00, 1'b0, 16'h0000);
    check_regs("fwd_wa_update", '{16'h0, 16'h0, 16'h1234, 16'h1111, 16'hBEEF, 16'h5A5A, 16'h0066, 16'h7777});

    // No strobe, no write
    run_instr(16'hC100, 1'b0, 16'hFFFF);
    check_regs("no_strobe", '{16'h0, 16'h0, 16'h1234, 16'h1111, 16'hBEEF, 16'h5A5A, 16'h0066, 16'h7777});

    // Mid-instruction reset with a write pending
    phase = P3;
    instr = 16'hC300;
    rf_enable = 1'b1;
    result = 16'hDEAD;
    #3 rst_n = 1'b0;
    model_reset();
    phase = P0;
    rf_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_ar", ar, 16'h0000);
    check("midrst_br", br, 16'h0000);
    check_regs("midrst_regs", '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

    // First write after reset goes to R0
    step(P3, 16'hC600, 1'b1, 16'h0BAD);
    step(P0, 16'hC600, 1'b0, 16'h0000);
    check_regs("first_wr_r0", '{16'h0BAD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    step(P1, 16'hC600, 1'b0, 16'h0000);
    check("rd_r0_ar", ar, 16'h0BAD);
    step(P0, 16'hC600, 1'b0, 16'h0000);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
